ccff_loader: RTL and testbench
==============================

// Module: ccff_loader
// PURPOSE
//  Sequences bitstream loading into the fabric's configuration flip-flop chain (ccff_head/ccff_tail).
//  Accepts configuration bytes over a valid/ready stream and serialises them MSB-first onto ccff_head.
//  Emits one prog_clk_en strobe per bit and counts bits up to CHAIN_LEN.
//  Holds the fabric in reset while loading and releases it once the chain is full.
//  Sits between the top-level pin wrapper and fpga_top.
// PARAMETERS
//  CHAIN_LEN  64                        total config bits in the chain (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)       width of bit_count
// PORTS
//  clk          in   1      system clock; also source of the gated prog_clk
//  pReset       in   1      synchronous, active-high reset
//  start        in   1      1-cycle pulse: begin a load (honoured only in IDLE or DONE)
//  abort        in   1      abandon current load, return to IDLE
//  din          in   8      config byte, MSB shifted first
//  din_valid    in   1      din holds a valid byte
//  din_ready    out  1      loader accepts din this cycle
//  ccff_tail    in   1      chain output, sampled on every strobe
//  ccff_head    out  1      serial config bit into chain
//  prog_clk_en  out  1      gate enable for prog_clk; chain shifts on clk edge ending a high cycle
//  fabric_rst   out  1      active-high reset to user fabric
//  busy         out  1      load in progress
//  done         out  1      chain fully loaded (sticky until start/abort/reset)
//  bit_count    out  CNT_W  bits shifted in current load
//  tail_parity  out  1      XOR of all ccff_tail samples of current load (old-content check)
// BEHAVIOUR
//  Reset values: din_ready=0, ccff_head=0, prog_clk_en=0, fabric_rst=1, busy=0, done=0,
//   bit_count=0, tail_parity=0. FSM goes to IDLE.
//  FSM states are IDLE, FETCH, SETUP, PULSE and DONE.
//  IDLE:  fabric_rst=1.
//   - start -> FETCH; clear bit_count and tail_parity; busy=1.
//  FETCH: din_ready=1.
//   - On din_valid&din_ready, load shift reg=din; bits_left_in_byte=8; go SETUP.
//   - Stalls indefinitely without valid; no timeout.
//  SETUP: ccff_head=shreg[7], prog_clk_en=0.
//   - Holds head stable one cycle before the strobe, then PULSE.
//  PULSE: ccff_head unchanged, prog_clk_en=1 for exactly one cycle.
//   - Same cycle: bit_count+=1; tail_parity^=ccff_tail; shreg<<=1; bits_left-=1.
//   - Next state by priority:
//     (1) bit_count+1==CHAIN_LEN -> DONE;
//     (2) bits_left==1 -> FETCH;
//     (3) else SETUP.
//  Bit period is 2 clk cycles; a byte costs 16 cycles plus the handshake.
//  DONE: busy=0, done=1, prog_clk_en=0.
//   - fabric_rst deasserts on the first DONE cycle.
//   - Unused low bits of the final byte are discarded.
//   - din_ready=0; no further bytes consumed.
//   - start in DONE begins a new load: fabric_rst=1, done=0.
//  Boundaries:
//   - start while busy is ignored.
//   - abort takes priority over all inputs except pReset; next cycle the FSM is in IDLE.
//     prog_clk_en=0, fabric_rst=1, done=0; bit_count is held for debug.
//   - abort and start in the same cycle: abort wins.
//   - pReset mid-load gives reset values; a partial chain is considered invalid.
//   - prog_clk_en never high in two consecutive cycles; never high outside PULSE.
//   - bit_count saturates at CHAIN_LEN and never wraps.
// TESTING
//  1 CHAIN_LEN=12; start; bytes 0xA5,0x3C.
//    -> head bits 1,0,1,0,0,1,0,1,0,0,1,1; 12 strobes.
//    -> 0x3C low nibble dropped; done=1; fabric_rst falls.
//  2 Insert 5 idle din_valid cycles between bytes.
//    -> no strobes during the gap; bit sequence identical to test 1.
//  3 Tie ccff_tail=1 through 12 strobes -> tail_parity=0; with tail=1 on only 3 strobes -> tail_parity=1.
//  4 abort after 5 strobes.
//    -> next cycle IDLE, prog_clk_en=0, fabric_rst=1, done=0, bit_count=5.
//    -> a fresh start/full load then succeeds.
//  5 Pulse start while busy -> ignored; assert pReset mid-byte -> all outputs at reset values the next cycle.
//  6 Start in DONE -> done clears, fabric_rst=1, bit_count=0, din_ready=1 the next cycle.

Source files
------------

// File: rtl/ccff_loader.sv
// Configuration-chain loader: takes bytes over a valid/ready stream and shifts them
// MSB-first into the fabric's ccff chain, one prog_clk strobe per bit, holding the fabric in reset.
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             pReset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             ccff_tail,
    output logic             ccff_head,
    output logic             prog_clk_en,
    output logic             fabric_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count,
    output logic             tail_parity,
    output logic [2:0]       state_dbg
);

    // Handshake: a byte transfers on a rising clk edge where din_valid and din_ready are both 1;
    // din_ready is only high in FETCH, and din must be held stable while din_valid is high.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             tail_parity_q, tail_parity_d;
    logic             ccff_head_q, ccff_head_d;
    logic             din_ready_q, din_ready_d;
    logic             prog_clk_en_q, prog_clk_en_d;
    logic             fabric_rst_q, fabric_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bits_left_d   = bits_left_q;
        bit_count_d   = bit_count_q;
        tail_parity_d = tail_parity_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_FETCH;
                    bit_count_d   = '0;
                    tail_parity_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (din_valid) begin
                    shreg_d     = din;
                    bits_left_d = 4'd8;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: begin
                if (bit_count_q != LAST_COUNT) begin
                    bit_count_d = bit_count_q + ONE;
                end
                tail_parity_d = tail_parity_q ^ ccff_tail;
                shreg_d       = {shreg_q[6:0], 1'b0};
                bits_left_d   = bits_left_q - 4'd1;
                // A full chain wins over a byte boundary, so leftover low bits are dropped.
                if (bit_count_q + ONE == LAST_COUNT) begin
                    state_d = S_DONE;
                end else if (bits_left_q == 4'd1) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the datapath (bit_count stays readable) and drops back to IDLE.
        if (abort) begin
            state_d       = S_IDLE;
            shreg_d       = shreg_q;
            bits_left_d   = bits_left_q;
            bit_count_d   = bit_count_q;
            tail_parity_d = tail_parity_q;
        end

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        din_ready_d   = (state_d == S_FETCH);
        prog_clk_en_d = (state_d == S_PULSE);
        busy_d        = (state_d == S_FETCH) || (state_d == S_SETUP) || (state_d == S_PULSE);
        done_d        = (state_d == S_DONE);
        fabric_rst_d  = (state_d != S_DONE);
        ccff_head_d   = (state_d == S_SETUP) ? shreg_d[7] : ccff_head_q;
    end

    always_ff @(posedge clk) begin
        if (pReset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bits_left_q   <= '0;
            bit_count_q   <= '0;
            tail_parity_q <= 1'b0;
            ccff_head_q   <= 1'b0;
            din_ready_q   <= 1'b0;
            prog_clk_en_q <= 1'b0;
            fabric_rst_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bits_left_q   <= bits_left_d;
            bit_count_q   <= bit_count_d;
            tail_parity_q <= tail_parity_d;
            ccff_head_q   <= ccff_head_d;
            din_ready_q   <= din_ready_d;
            prog_clk_en_q <= prog_clk_en_d;
            fabric_rst_q  <= fabric_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign din_ready   = din_ready_q;
    assign ccff_head   = ccff_head_q;
    assign prog_clk_en = prog_clk_en_q;
    assign fabric_rst  = fabric_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_count   = bit_count_q;
    assign tail_parity = tail_parity_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader with a 12-bit chain: directed loads checked every cycle against
// an offset-based timeline model, plus literal expectations for the key scenarios.
module tb_ccff_loader;

  localparam int LEN = 12;
  localparam int CW  = $clog2(LEN + 1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          p_reset;
  logic          start;
  logic          abort;
  logic [7:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic          ccff_tail;
  logic          ccff_head;
  logic          prog_clk_en;
  logic          fabric_rst;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;
  logic          tail_parity;
  logic [2:0]    state_dbg;

  ccff_loader #(.CHAIN_LEN(LEN)) dut (
    .clk(clk), .pReset(p_reset), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ccff_tail(ccff_tail), .ccff_head(ccff_head), .prog_clk_en(prog_clk_en),
    .fabric_rst(fabric_rst), .busy(busy), .done(done),
    .bit_count(bit_count), .tail_parity(tail_parity), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: 0 idle, 1 waiting for a byte, 2 shifting a byte, 3 chain full
  int         m_mode = 0;
  int         ecnt   = 0;
  int         m_hs   = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_cnt  = 0;
  logic       m_par  = 1'b0;

  // strobe recorder and ccff_tail pattern
  logic [63:0] rec_bits  = '0;
  int          rec_n     = 0;
  int          rec_base  = 0;
  int          tail_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Byte k of a load is handed over at edge hs; its strobe j occupies the cycle after
  // edge hs+2j+1 and is counted at edge hs+2j+2.
  task automatic model_step();
    int off;
    ecnt++;
    if (p_reset) begin
      m_mode = 0; m_cnt = 0; m_par = 1'b0;
    end else if (abort) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin m_mode = 1; m_cnt = 0; m_par = 1'b0; end
        1: if (din_valid) begin m_mode = 2; m_hs = ecnt; m_byte = din; end
        2: begin
          off = ecnt - m_hs;
          if (off % 2 == 0) begin
            m_cnt++;
            m_par = m_par ^ ccff_tail;
            if (m_cnt == LEN) m_mode = 3;
            else if (off == 16) m_mode = 1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic compare();
    int off;
    off = ecnt - m_hs;
    chk("din_ready", int'(din_ready), int'(m_mode == 1));
    chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
    chk("done", int'(done), int'(m_mode == 3));
    chk("fabric_rst", int'(fabric_rst), int'(m_mode != 3));
    chk("bit_count", int'(bit_count), m_cnt);
    chk("tail_parity", int'(tail_parity), int'(m_par));
    chk("prog_clk_en", int'(prog_clk_en), int'(m_mode == 2 && (off % 2 == 1)));
    if (m_mode == 2) chk("ccff_head", int'(ccff_head), int'(m_byte[7 - (off / 2)]));
  endtask

  // One clock: model and compare just after the edge, then update recorder and tail.
  task automatic tick();
    int k;
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (prog_clk_en) begin
      rec_bits = {rec_bits[62:0], ccff_head};
      rec_n++;
    end
    k = rec_n - rec_base;
    case (tail_mode)
      1:       ccff_tail = 1'b1;
      2:       ccff_tail = (k >= 1 && k <= 3);
      default: ccff_tail = 1'b0;
    endcase
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    din_valid = 1'b0;
    n = 0;
    while (gap > 0 && !din_ready && n < 200) begin tick(); n++; end
    repeat (gap) tick();
    din = b;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 200) begin tick(); n++; end
    if (!din_ready) chk("handshake_timeout", 0, 1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while ((rec_n - rec_base) < target && n < 200) begin tick(); n++; end
    chk("strobe_wait", rec_n - rec_base, target);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_din_ready"}, int'(din_ready), 0);
    chk({tag, "_ccff_head"}, int'(ccff_head), 0);
    chk({tag, "_prog_clk_en"}, int'(prog_clk_en), 0);
    chk({tag, "_fabric_rst"}, int'(fabric_rst), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_bit_count"}, int'(bit_count), 0);
    chk({tag, "_tail_parity"}, int'(tail_parity), 0);
  endtask

  task automatic full_load(input int gap);
    rec_base = rec_n;
    send_byte(8'hA5, 0);
    send_byte(8'h3C, gap);
    wait_done();
    chk("strobe_total", rec_n - rec_base, 12);
    chk("head_bits", int'(rec_bits[11:0]), 12'hA53);
    chk("final_bit_count", int'(bit_count), 12);
    chk("final_fabric_rst", int'(fabric_rst), 0);
  endtask

  initial begin
    p_reset = 1'b1; start = 1'b0; abort = 1'b0;
    din = 8'h00; din_valid = 1'b0; ccff_tail = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    p_reset = 1'b0;
    tick();

    // test 1: plain load, 0x3C low nibble dropped
    pulse_start();
    full_load(0);
    repeat (4) tick();
    chk("done_sticky", int'(done), 1);

    // test 6 then test 2: restart from DONE, stall 5 cycles between bytes
    pulse_start();
    chk("restart_done", int'(done), 0);
    chk("restart_fabric_rst", int'(fabric_rst), 1);
    chk("restart_bit_count", int'(bit_count), 0);
    chk("restart_din_ready", int'(din_ready), 1);
    full_load(5);

    // test 3: tail parity
    tail_mode = 1;
    pulse_start();
    full_load(0);
    chk("parity_all_ones", int'(tail_parity), 0);
    tail_mode = 2;
    pulse_start();
    full_load(0);
    chk("parity_three_ones", int'(tail_parity), 1);
    tail_mode = 0;

    // test 4: abort after five strobes, then a fresh load
    pulse_start();
    rec_base = rec_n;
    send_byte(8'hA5, 0);
    wait_strobes(5);
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_prog_clk_en", int'(prog_clk_en), 0);
    chk("abort_fabric_rst", int'(fabric_rst), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_bit_count", int'(bit_count), 5);
    repeat (3) tick();
    pulse_start();
    full_load(0);

    // test 5: start while busy is ignored, then reset mid-byte
    pulse_start();
    rec_base = rec_n;
    send_byte(8'h96, 0);
    wait_strobes(2);
    pulse_start();
    wait_strobes(4);
    chk("busy_start_ignored", int'(bit_count), 3);
    p_reset = 1'b1;
    tick();
    check_reset_values("midreset");
    p_reset = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
